seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the team's single-cycle ALU.
- Keeps opcodes 0-7 bit-identical in result, and adds shifts, unsigned compare, NOR and a multicycle shift-add multiply.
- Adds carry, overflow, negative and error flags.
- Sits between the register-file read stage and writeback, with valid/ready handshakes on both sides so a multicycle op can stall the producer.

Parameters:
- word_size, 32, datapath width in bits; must be at least 4.
- mult_enable, 1, 1 implements MUL (op 4'hC); 0 treats 4'hC as reserved.
- SHW, $clog2(word_size), derived (localparam); width of the shift amount.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- in_valid, in, 1, operands and op are valid.
- in_ready, out, 1, block can accept; transfer when in_valid && in_ready.
- R2, in, word_size, operand A.
- R3, in, word_size, operand B / shift amount.
- ALUOp, in, 4, operation select.
- out_valid, out, 1, result registers hold an unconsumed result.
- out_ready, in, 1, consumer accepts; result consumed when out_valid && out_ready.
- R1, out, word_size, result (registered).
- Zero, out, 1, R1 == 0.
- Neg, out, 1, R1[word_size-1].
- Carry, out, 1, carry out (ADD/SUB only).
- Ovf, out, 1, signed overflow (ADD/SUB only).
- Err, out, 1, reserved opcode was issued.

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; count = 0.
  - R1 = 0; Zero, Neg, Carry, Ovf, Err = 0; out_valid = 0.
  - Reset mid-MUL aborts the op and discards partial products.
- Opcodes:
  - 0 PASS R2; 1 NOT R2; 2 ADD; 3 SUB; 4 OR; 5 AND; 6 XOR.
  - 7 SLT signed (result is 1 or 0); 8 SLTU unsigned (1 or 0).
  - 9 SLL R2 << R3[SHW-1:0]; A SRL (logical); B SRA (arithmetic). Upper bits of R3 are ignored.
  - C MUL: low word_size bits of R2*R3; signedness is irrelevant for the low word.
  - D NOR.
  - E, F reserved: R1 = 0, Err = 1.
- Flags:
  - Carry: ADD = carry out of R2+R3. SUB = carry out of R2+~R3+1, so 1 means no borrow.
  - Ovf: ADD/SUB signed overflow.
  - Carry and Ovf are 0 for every other op.
  - Err is 0 for all valid ops.
  - Zero and Neg are always derived from the R1 value being written.
- in_ready = (state == IDLE) && (!out_valid || out_ready). The block accepts the next op in the same cycle the current result is consumed.
- State IDLE:
  - Accept of a single-cycle op at edge E: R1 and flags load at E, out_valid = 1 after E. Latency is 1 edge.
  - Accept of MUL at edge E:
    - Latch multiplicand and multiplier; clear the accumulator; count = word_size.
    - Go to MULT; out_valid = 0.
- State MULT:
  - in_ready = 0.
  - Each edge: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count -= 1.
  - On the edge where count goes 1 to 0: R1 = acc (including that final add), flags load, out_valid = 1, go to IDLE.
  - Result is visible after edge E+word_size.
- Output hold:
  - R1, flags and out_valid stay stable while out_valid && !out_ready.
  - out_valid clears on consume unless a new single-cycle op is accepted in the same cycle; then it stays 1 with the new data.
  - Consume with simultaneous MUL accept: out_valid drops to 0 for the whole MULT phase.
- Width rule: all arithmetic is modulo 2^word_size. SLT/SLTU results are zero-extended.
- No combinational path from in_valid to out_valid. in_ready depends only on state, out_valid and out_ready.

Test Plan:
- Reset then ops 0-7 with word_size = 32, R2 = 32'h0000_0005, R3 = 32'hFFFF_FFFB. Required results, each 1 cycle after accept:
  - ADD -> 0, Zero = 1, Carry = 1.
  - SLT -> 0.
  - SUB -> 32'h0000_000A.
  - NOT -> 32'hFFFF_FFFA, Neg = 1.
- Overflow and compare: ADD 32'h7FFF_FFFF + 1 -> 32'h8000_0000, Ovf = 1, Neg = 1. SLTU with R2 = 5, R3 = 32'hFFFF_FFFB -> 1.
- Shifts: SRA R2 = 32'h8000_0010, R3 = 32'h0000_0024 (amount 4) -> 32'hF800_0001. SRL same operands -> 32'h0800_0001.
- MUL 32'h0000_1234 * 32'h0000_0100:
  - in_ready = 0 for 32 cycles; out_valid rises exactly 32 edges after accept with R1 = 32'h0012_3400.
  - Repeat with mult_enable = 0: 1-cycle result, R1 = 0, Err = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after an ADD result. R1 stays stable and in_ready = 0. Raising out_ready with in_valid high accepts the next op in the same cycle with no bubble.
- Assert rst_n low at cycle 10 of a MUL: outputs go to 0 immediately. After release, an ADD 2+3 returns 5 with no MUL residue. Opcode 4'hE -> R1 = 0, Err = 1, Zero = 1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops load the result registers on the accepting edge; MUL runs
// a shift-add loop for word_size edges while holding off the producer.
module seq_alu #(
  parameter int word_size   = 32,
  parameter bit mult_enable = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [word_size-1:0] R2,
  input  logic [word_size-1:0] R3,
  input  logic [3:0]           ALUOp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word_size-1:0] R1,
  output logic                 Zero,
  output logic                 Neg,
  output logic                 Carry,
  output logic                 Ovf,
  output logic                 Err
);

  localparam int SHW = $clog2(word_size);
  localparam int CW  = $clog2(word_size + 1);
  localparam int MSB = word_size - 1;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_NOT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_NOR  = 4'hD;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [word_size-1:0] mcand_q, mcand_d;
  logic [word_size-1:0] mplier_q, mplier_d;
  logic [word_size-1:0] acc_q, acc_d;
  logic [word_size-1:0] r1_q, r1_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept_s;
  logic                 consume_s;
  logic                 is_mul_s;
  logic [SHW-1:0]       shamt_s;
  logic [word_size:0]   sum_s;
  logic [word_size:0]   diff_s;
  logic [word_size-1:0] alu_res_s;
  logic                 alu_carry_s;
  logic                 alu_ovf_s;
  logic                 alu_err_s;
  logic [word_size-1:0] acc_step_s;

  // Handshake: ready depends only on state and the output slot, never on in_valid.
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid_q && out_ready;
  assign is_mul_s  = (ALUOp == OP_MUL) && mult_enable;

  // Carry-out adders: SUB is R2 + ~R3 + 1 so carry = 1 means no borrow.
  assign shamt_s    = R3[SHW-1:0];
  assign sum_s      = {1'b0, R2} + {1'b0, R3};
  assign diff_s     = {1'b0, R2} + {1'b0, ~R3} + {{word_size{1'b0}}, 1'b1};
  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  assign R1        = r1_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;
  assign Carry     = carry_q;
  assign Ovf       = ovf_q;
  assign Err       = err_q;
  assign out_valid = out_valid_q;

  // Single-cycle result and flags for the op currently on the input port.
  always_comb begin
    alu_res_s   = {word_size{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_err_s   = 1'b0;
    case (ALUOp)
      OP_PASS: alu_res_s = R2;
      OP_NOT:  alu_res_s = ~R2;
      OP_ADD: begin
        alu_res_s   = sum_s[MSB:0];
        alu_carry_s = sum_s[word_size];
        alu_ovf_s   = (R2[MSB] == R3[MSB]) && (sum_s[MSB] != R2[MSB]);
      end
      OP_SUB: begin
        alu_res_s   = diff_s[MSB:0];
        alu_carry_s = diff_s[word_size];
        alu_ovf_s   = (R2[MSB] != R3[MSB]) && (diff_s[MSB] != R2[MSB]);
      end
      OP_OR:   alu_res_s = R2 | R3;
      OP_AND:  alu_res_s = R2 & R3;
      OP_XOR:  alu_res_s = R2 ^ R3;
      OP_SLT:  alu_res_s = {{(word_size-1){1'b0}}, ($signed(R2) < $signed(R3))};
      OP_SLTU: alu_res_s = {{(word_size-1){1'b0}}, (R2 < R3)};
      OP_SLL:  alu_res_s = R2 << shamt_s;
      OP_SRL:  alu_res_s = R2 >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(R2) >>> shamt_s);
      OP_MUL: begin
        // With the multiplier built in, MUL never takes this path's result.
        if (mult_enable) begin
          alu_err_s = 1'b0;
        end else begin
          alu_err_s = 1'b1;
        end
      end
      OP_NOR:  alu_res_s = ~(R2 | R3);
      default: alu_err_s = 1'b1;
    endcase
  end

  // Next-state: MUL accept enters MULT, leaving once the count reaches its last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mul_s) begin
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        if (count_q == CW'(1)) begin
          state_d = IDLE;
        end else begin
          state_d = MULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: result load, output hold and shift-add steps.
  always_comb begin
    count_d     = count_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    r1_d        = r1_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_mul_s) begin
            mcand_d     = R2;
            mplier_d    = R3;
            acc_d       = {word_size{1'b0}};
            count_d     = CW'(word_size);
            out_valid_d = 1'b0;
          end else begin
            r1_d        = alu_res_s;
            zero_d      = (alu_res_s == {word_size{1'b0}});
            neg_d       = alu_res_s[MSB];
            carry_d     = alu_carry_s;
            ovf_d       = alu_ovf_s;
            err_d       = alu_err_s;
            out_valid_d = 1'b1;
          end
        end else if (consume_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      MULT: begin
        acc_d    = acc_step_s;
        mcand_d  = {mcand_q[MSB-1:0], 1'b0};
        mplier_d = {1'b0, mplier_q[MSB:1]};
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          r1_d        = acc_step_s;
          zero_d      = (acc_step_s == {word_size{1'b0}});
          neg_d       = acc_step_s[MSB];
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= {CW{1'b0}};
      mcand_q     <= {word_size{1'b0}};
      mplier_q    <= {word_size{1'b0}};
      acc_q       <= {word_size{1'b0}};
      r1_q        <= {word_size{1'b0}};
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      r1_q        <= r1_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table through a result scoreboard, plus
// hand-written MUL latency, backpressure and mid-MUL reset sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  ALUOp = 4'h0;
  logic [31:0] R2 = 32'h0;
  logic [31:0] R3 = 32'h0;

  logic        in_ready, out_valid, Zero, Neg, Carry, Ovf, Err;
  logic [31:0] R1;
  logic        nm_in_ready, nm_out_valid, nm_Zero, nm_Neg, nm_Carry, nm_Ovf, nm_Err;
  logic [31:0] nm_R1;

  seq_alu #(.word_size(32), .mult_enable(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .R2(R2), .R3(R3), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .R1(R1), .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .Err(Err)
  );

  seq_alu #(.word_size(32), .mult_enable(1'b0)) u_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nm_in_ready),
    .R2(R2), .R3(R3), .ALUOp(ALUOp), .out_valid(nm_out_valid), .out_ready(out_ready),
    .R1(nm_R1), .Zero(nm_Zero), .Neg(nm_Neg), .Carry(nm_Carry), .Ovf(nm_Ovf), .Err(nm_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [4:0]  fl;   // {Zero, Neg, Carry, Ovf, Err}
  } vec_t;

  typedef struct {
    logic [31:0] r1;
    logic [4:0]  fl;
  } res_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  res_t sb_q [$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one op from a negedge, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r1, input logic [4:0] fl, input bit expect_out);
    res_t e;
    int   t;
    @(negedge clk);
    ALUOp = op; R2 = a; R3 = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1 op=%h", in_ready, op);
      in_valid = 1'b0;
      return;
    end
    if (expect_out) begin
      e.r1 = r1;
      e.fl = fl;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every consumed result against the queue head.
  always @(negedge clk) begin
    res_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got R1=%h, expected no output", R1);
      end else begin
        e = sb_q.pop_front();
        check("result", 64'({R1, Zero, Neg, Carry, Ovf, Err}), 64'({e.r1, e.fl}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    tbl[0]  = '{4'h0, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0005, 5'b00000};
    tbl[1]  = '{4'h1, 32'h0000_0005, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'b01000};
    tbl[2]  = '{4'h2, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 5'b10100};
    tbl[3]  = '{4'h3, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_000A, 5'b00000};
    tbl[4]  = '{4'h4, 32'h0000_0005, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 5'b01000};
    tbl[5]  = '{4'h5, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0001, 5'b00000};
    tbl[6]  = '{4'h6, 32'h0000_0005, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 5'b01000};
    tbl[7]  = '{4'h7, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 5'b10000};
    tbl[8]  = '{4'h8, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0001, 5'b00000};
    tbl[9]  = '{4'hD, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 5'b10000};
    tbl[10] = '{4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010};
    tbl[11] = '{4'hB, 32'h8000_0010, 32'h0000_0024, 32'hF800_0001, 5'b01000};
    tbl[12] = '{4'hA, 32'h8000_0010, 32'h0000_0024, 32'h0800_0001, 5'b00000};
    tbl[13] = '{4'h9, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 5'b00000};
    tbl[14] = '{4'h3, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 5'b01000};
    tbl[15] = '{4'h3, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 5'b00100};
    tbl[16] = '{4'h3, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00110};
    tbl[17] = '{4'hF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 5'b10001};
    tbl[18] = '{4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00000};
    tbl[19] = '{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10000};
    tbl[20] = '{4'h9, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 5'b01000};
    tbl[21] = '{4'hB, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 5'b01000};

    // Reset state
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({R1, Zero, Neg, Carry, Ovf, Err, out_valid}), 64'h0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'h1);

    // Table of single-cycle ops, issued back to back
    for (int i = 0; i < NV; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r1, tbl[i].fl, 1'b1);
    end

    // MUL: busy for 32 cycles, result exactly 32 edges after accept
    send(4'hC, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 5'b00000, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) ok = 1'b0;
      if (k == 0) begin
        check("nomul_reserved", 64'({nm_out_valid, nm_R1, nm_Err, nm_Zero, nm_Carry, nm_Ovf}),
              64'({1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
      end
    end
    check("mul_busy", 64'(ok), 64'h1);
    @(negedge clk);
    check("mul_latency", 64'(out_valid), 64'h1);

    // Backpressure: result held for 5 cycles, then consume + accept in one edge
    send(4'h2, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 5'b00000, 1'b1);
    out_ready = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (R1 !== 32'h5 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    check("backpressure_hold", 64'(ok), 64'h1);
    @(negedge clk);
    ALUOp = 4'h6; R2 = 32'hF0F0_F0F0; R3 = 32'hFF00_FF00; in_valid = 1'b1; out_ready = 1'b1;
    #0;
    check("same_cycle_accept", 64'(in_ready), 64'h1);
    sb_q.push_back('{32'h0FF0_0FF0, 5'b00000});
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("no_bubble", 64'({out_valid, R1}), 64'({1'b1, 32'h0FF0_0FF0}));

    // Reset in the middle of a MUL
    send(4'hC, 32'h0000_1234, 32'h0000_0100, 32'h0, 5'b00000, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_mul", 64'({R1, Zero, Neg, Carry, Ovf, Err, out_valid}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(4'h2, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 5'b00000, 1'b1);
    send(4'hE, 32'h0000_0007, 32'h0000_0009, 32'h0000_0000, 5'b10001, 1'b1);

    // Drain the scoreboard (bounded)
    for (int t = 0; t < 50; t++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    #2;
    check("scoreboard_drain", 64'(sb_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
